recip_div: RTL and testbench

RECIP_DIV -- requirements
Module: recip_div

---
 rtl/recip_div_if.sv | 21 ++
 rtl/recip_div.sv | 97 +++++++++
 tb/tb_recip_div.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/recip_div_if.sv
// Handshake bundle for the reciprocal divider: one 8-bit divisor in, one
// 12-bit reciprocal plus divide-by-zero flag out.
interface recip_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  number;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] inverse;
  logic        div_zero;

  modport master (
    output in_valid, number, out_ready,
    input  in_ready, out_valid, inverse, div_zero
  );

  modport slave (
    input  in_valid, number, out_ready,
    output in_ready, out_valid, inverse, div_zero
  );
endinterface

// File: rtl/recip_div.sv
// Sequential reciprocal: inverse = min(floor(4096/n), 4095), computed by a
// 13-step restoring division, one quotient bit per cycle.
module recip_div (
  input  logic         clk,
  input  logic         rst,
  recip_div_if.slave   bus_io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [8:0]  rem_q, rem_d;
  logic [12:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] inv_q, inv_d;
  logic        dz_q, dz_d;

  logic [9:0]  rem_sh;
  logic        qbit;

  function automatic logic [11:0] sat12(input logic [12:0] q);
    return q[12] ? 12'hFFF : q[11:0];
  endfunction

  always_comb begin
    // Dividend 0x1000 has a single set bit, fed in on the first step.
    rem_sh  = {rem_q, (cnt_q == 4'd12)};
    qbit    = (rem_sh >= {2'b00, n_q});

    state_d = state_q;
    n_d     = n_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus_io.in_valid) begin
          n_d   = bus_io.number;
          rem_d = '0;
          quo_d = '0;
          cnt_d = 4'd12;
          if (bus_io.number >= 8'd2) begin
            state_d = CALC;
          end else begin
            state_d = DONE;
            inv_d   = 12'hFFF;
            dz_d    = (bus_io.number == 8'd0);
          end
        end
      end
      CALC: begin
        rem_d = 9'(qbit ? (rem_sh - {2'b00, n_q}) : rem_sh);
        quo_d = 13'({quo_q, qbit});
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          inv_d   = sat12(quo_d);
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        if (bus_io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      dz_q    <= dz_d;
    end
  end

  assign bus_io.in_ready  = (state_q == IDLE);
  assign bus_io.out_valid = (state_q == DONE);
  assign bus_io.inverse   = inv_q;
  assign bus_io.div_zero  = dz_q;

endmodule

// File: tb/tb_recip_div.sv
// Directed bench for recip_div: latency, back-to-back, edge divisors,
// backpressure, mid-operation reset and a full divisor sweep.
module tb_recip_div;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  recip_div_if bus ();

  recip_div dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive one number; returns just after the accepting edge.
  task automatic send(input logic [7:0] n);
    int c = 0;
    while (!bus.in_ready && c < 50) begin
      tick();
      c++;
    end
    chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.number   = n;
    tick();
    bus.in_valid = 1'b0;
    bus.number   = 8'($urandom);
  endtask

  // Latency counted so that a result visible right after the accept edge is 1.
  task automatic wait_valid(input bit rnd, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    if (rnd) bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0]  vals [4];
    logic [11:0] exps [4];
    logic [11:0] exp_inv;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.number    = 8'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_inverse",   32'(bus.inverse),   32'd0);
    chk("rst_div_zero",  32'(bus.div_zero),  32'd0);

    // n=250 accepted on the very first edge after reset release
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    send(8'd250);
    for (int i = 1; i < 13; i++) tick();
    chk("n250_not_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("n250_out_valid", 32'(bus.out_valid), 32'd1);
    chk("n250_inverse",   32'(bus.inverse),   32'd16);
    chk("n250_div_zero",  32'(bus.div_zero),  32'd0);
    chk("n250_busy",      32'(bus.in_ready),  32'd0);
    tick();
    chk("n250_consumed",  32'(bus.out_valid), 32'd0);
    tick();
    chk("n250_in_ready",  32'(bus.in_ready),  32'd1);

    // back-to-back with in_valid held high
    vals = '{8'd3, 8'd10, 8'd100, 8'd200};
    exps = '{12'd1365, 12'd409, 12'd40, 12'd20};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.number = vals[i];
      chk("b2b_ready", 32'(bus.in_ready), 32'd1);
      tick();
      if (i == 3) bus.in_valid = 1'b0;
      bus.number = (i < 3) ? vals[i+1] : 8'd0;
      wait_valid(1'b0, lat);
      chk("b2b_latency", 32'(lat), 32'd14);
      chk("b2b_inverse", 32'(bus.inverse), 32'(exps[i]));
      chk("b2b_one_at_a_time", 32'(bus.in_ready), 32'd0);
      tick();
    end

    // n=1 saturates, n=0 flags divide by zero
    send(8'd1);
    wait_valid(1'b0, lat);
    chk("n1_latency",  32'(lat), 32'd1);
    chk("n1_inverse",  32'(bus.inverse),  32'd4095);
    chk("n1_div_zero", 32'(bus.div_zero), 32'd0);
    tick();
    send(8'd0);
    wait_valid(1'b0, lat);
    chk("n0_latency",  32'(lat), 32'd1);
    chk("n0_inverse",  32'(bus.inverse),  32'd4095);
    chk("n0_div_zero", 32'(bus.div_zero), 32'd1);
    tick();

    // backpressure on n=7 with input noise
    bus.out_ready = 1'b0;
    send(8'd7);
    wait_valid(1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.number   = 8'($urandom);
      tick();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_inverse",   32'(bus.inverse),   32'd585);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_released", 32'(bus.out_valid), 32'd0);

    // reset in the middle of n=50
    send(8'd50);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_inverse",   32'(bus.inverse),   32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("mid_rst_no_result", 32'(bus.out_valid), 32'd0);
    send(8'd50);
    wait_valid(1'b0, lat);
    chk("n50_latency", 32'(lat), 32'd14);
    chk("n50_inverse", 32'(bus.inverse), 32'd81);
    tick();

    // full sweep with random stalls
    for (int n = 0; n < 256; n++) begin
      if (n == 0) exp_inv = 12'hFFF;
      else        exp_inv = ((4096 / n) > 4095) ? 12'hFFF : 12'(4096 / n);
      bus.out_ready = 1'b0;
      send(8'(n));
      wait_valid(1'b1, lat);
      chk("sweep_latency", 32'(lat), (n >= 2) ? 32'd14 : 32'd1);
      repeat ($urandom_range(0, 2)) tick();
      chk("sweep_inverse",  32'(bus.inverse),  32'(exp_inv));
      chk("sweep_div_zero", 32'(bus.div_zero), (n == 0) ? 32'd1 : 32'd0);
      bus.out_ready = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
